// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - opcodes, FSM encoding and command packing shared by the calculator sequencer
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_SHR = 2'b11;

    localparam int OP_W        = 2;
    localparam int HOLD_W      = 4;
    localparam int ISSUE_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } seq_state_t;

    // A queued command is packed as {op, a, b}
    function automatic int cmd_width(input int data_w);
        return OP_W + 2 * data_w;
    endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// rtl/calc_cmd_fifo.sv - power-of-two command FIFO holding packed {op,a,b} entries
module calc_cmd_fifo
    import calc_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [cmd_width(DATA_W)-1:0] din,
    output logic [cmd_width(DATA_W)-1:0] dout,
    output logic                         full,
    output logic                         empty
);

    localparam int W     = cmd_width(DATA_W);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - queues calculator commands and issues them as one-hot strobes with a hold gap
// Optional OVERFLOW_CHECK_EN: registers add-carry / sub-borrow of each issued command on ovf_flag.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W      = 3,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [DATA_W-1:0]      cmd_a,
    input  logic [DATA_W-1:0]      cmd_b,
    output logic                   op1,
    output logic                   op2,
    output logic                   op3,
    output logic                   op4,
    output logic [DATA_W-1:0]      in1,
    output logic [DATA_W-1:0]      in2,
    output logic                   busy,
    output logic [ISSUE_CNT_W-1:0] issue_count,
    output logic                   ovf_flag
);

    localparam int              CMD_W       = cmd_width(DATA_W);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

    seq_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              full;
    logic              empty;
    logic              pop;
    logic [CMD_W-1:0]  head;
    logic [OP_W-1:0]   head_op;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;

    assign {head_op, head_a, head_b} = head;
    assign cmd_ready = !full;
    assign busy      = !empty || (state != ST_IDLE);

    calc_cmd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (cmd_valid),
        .pop   (pop),
        .din   ({cmd_op, cmd_a, cmd_b}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // The pop happens on the same edge that loads the issue registers
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE:  pop = !empty;
            ST_ISSUE: pop = (HOLD_CYCLES == 0) && !empty;
            ST_HOLD:  pop = (hold_cnt == '0) && !empty;
            default:  pop = 1'b0;
        endcase
    end

`ifdef OVERFLOW_CHECK_EN
    logic head_ovf;

    always_comb begin
        head_ovf = 1'b0;
        case (head_op)
            OP_ADD:  head_ovf = ({1'b0, head_a} + {1'b0, head_b}) > {1'b0, {DATA_W{1'b1}}};
            OP_SUB:  head_ovf = (head_a < head_b);
            default: head_ovf = 1'b0;
        endcase
    end
`else
    assign ovf_flag = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            {op4, op3, op2, op1} <= 4'b0000;
            in1         <= '0;
            in2         <= '0;
            issue_count <= '0;
`ifdef OVERFLOW_CHECK_EN
            ovf_flag    <= 1'b0;
`endif
        end else begin
            {op4, op3, op2, op1} <= 4'b0000;
            if (pop) begin
                state                <= ST_ISSUE;
                {op4, op3, op2, op1} <= 4'b0001 << head_op;
                in1                  <= head_a;
                in2                  <= head_b;
                issue_count          <= issue_count + 8'd1;
`ifdef OVERFLOW_CHECK_EN
                ovf_flag             <= head_ovf;
`endif
            end else begin
                case (state)
                    ST_ISSUE: begin
                        state    <= (HOLD_CYCLES > 0) ? ST_HOLD : ST_IDLE;
                        hold_cnt <= HOLD_RELOAD;
                    end
                    ST_HOLD: begin
                        if (hold_cnt == '0) state <= ST_IDLE;
                        else                hold_cnt <= hold_cnt - 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb/tb_calc_op_sequencer.sv - three sequencer instances (hold 1/2/0) checked every cycle against a timing model
module tb_calc_op_sequencer;
    import calc_pkg::*;

    localparam int DATA_W = 3;
    localparam int DEPTH  = 4;
    localparam int NDUT   = 3;
    localparam int LOGN   = 300;
`ifdef OVERFLOW_CHECK_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [1:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    logic              clock = 1'b0;
    logic              reset;
    logic [NDUT-1:0]   cmd_valid;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [NDUT-1:0]   cmd_ready, op1, op2, op3, op4, busy, ovf;
    logic [DATA_W-1:0] in1 [NDUT];
    logic [DATA_W-1:0] in2 [NDUT];
    logic [7:0]        icnt [NDUT];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    calc_op_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_CYCLES(1)) u_h1 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .op1(op1[0]), .op2(op2[0]), .op3(op3[0]),
        .op4(op4[0]), .in1(in1[0]), .in2(in2[0]), .busy(busy[0]), .issue_count(icnt[0]), .ovf_flag(ovf[0]));
    calc_op_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_CYCLES(2)) u_h2 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .op1(op1[1]), .op2(op2[1]), .op3(op3[1]),
        .op4(op4[1]), .in1(in1[1]), .in2(in2[1]), .busy(busy[1]), .issue_count(icnt[1]), .ovf_flag(ovf[1]));
    calc_op_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_CYCLES(0)) u_h0 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .op1(op1[2]), .op2(op2[2]), .op3(op3[2]),
        .op4(op4[2]), .in1(in1[2]), .in2(in2[2]), .busy(busy[2]), .issue_count(icnt[2]), .ovf_flag(ovf[2]));

    function automatic int hold_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic ovf_of(input cmd_t c);
        if (!OVF_ON) return 1'b0;
        if (c.op == OP_ADD) return (int'(c.a) + int'(c.b)) > (2 ** DATA_W - 1);
        if (c.op == OP_SUB) return int'(c.a) < int'(c.b);
        return 1'b0;
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: an issue may happen on any edge where something was queued beforehand
    // and at least HOLD+1 edges have passed since the previous issue.
    int                cyc;
    cmd_t              mq [NDUT][DEPTH];
    int                mcnt [NDUT];
    int                last [NDUT];
    logic [3:0]        e_op [NDUT];
    logic [DATA_W-1:0] e_in1 [NDUT];
    logic [DATA_W-1:0] e_in2 [NDUT];
    logic [7:0]        e_icnt [NDUT];
    logic              e_ovf [NDUT];

    task automatic model_clear();
        cyc = 0;
        for (int i = 0; i < NDUT; i++) begin
            mcnt[i] = 0; last[i] = -1000; e_op[i] = '0;
            e_in1[i] = '0; e_in2[i] = '0; e_icnt[i] = '0; e_ovf[i] = 1'b0;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_clear();
            else begin
                cyc = cyc + 1;
                for (int i = 0; i < NDUT; i++) begin
                    bit acc;
                    acc = cmd_valid[i] && (mcnt[i] < DEPTH);
                    e_op[i] = '0;
                    if (mcnt[i] > 0 && (cyc - last[i]) > hold_of(i)) begin
                        e_op[i]   = 4'b0001 << mq[i][0].op;
                        e_in1[i]  = mq[i][0].a;
                        e_in2[i]  = mq[i][0].b;
                        e_icnt[i] = e_icnt[i] + 8'd1;
                        e_ovf[i]  = ovf_of(mq[i][0]);
                        last[i]   = cyc;
                        for (int k = 0; k < DEPTH - 1; k++) mq[i][k] = mq[i][k+1];
                        mcnt[i]--;
                    end
                    if (acc) begin
                        mq[i][mcnt[i]] = '{cmd_op, cmd_a, cmd_b};
                        mcnt[i]++;
                    end
                end
            end
        end
    end

    int slog [NDUT][LOGN];
    int scnt [NDUT];

    initial begin
        for (int i = 0; i < NDUT; i++) scnt[i] = 0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < NDUT; i++) begin
                logic [20:0] got, exp;
                logic        e_busy;
                e_busy = (mcnt[i] > 0) || ((cyc - last[i]) <= hold_of(i));
                got = {cmd_ready[i], busy[i], op4[i], op3[i], op2[i], op1[i], in1[i], in2[i], icnt[i], ovf[i]};
                exp = {mcnt[i] < DEPTH, e_busy, e_op[i], e_in1[i], e_in2[i], e_icnt[i], e_ovf[i]};
                check(got === exp, $sformatf("cycle%0d_dut%0d", cyc, i), 32'(got), 32'(exp));
                if (reset) scnt[i] = 0;
                else if ({op4[i], op3[i], op2[i], op1[i]} != 4'b0000 && scnt[i] < LOGN) begin
                    slog[i][scnt[i]] = cyc;
                    scnt[i]++;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input int d, input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        bit r;
        int guard;
        cmd_op = op; cmd_a = a; cmd_b = b;
        cmd_valid = '0;
        cmd_valid[d] = 1'b1;
        guard = 0;
        do begin
            r = cmd_ready[d];
            @(negedge clock);
            guard++;
        end while (!r && guard < 50);
        check(r, "push_accept", 32'(r), 1);
    endtask

    task automatic do_reset();
        cmd_valid = '0;
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = '0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        cycles(2);
        check(cmd_ready === 3'b111, "reset_ready", 32'(cmd_ready), 7);
        check({busy, op1, op2, op3, op4} === '0, "reset_outputs", 32'({busy, op1, op2, op3, op4}), 0);
        check(icnt[0] === 8'd0, "reset_count", 32'(icnt[0]), 0);
        reset = 1'b0;

        // add 1+7: strobe exactly one cycle, two edges after the push
        push(0, OP_ADD, 3'd1, 3'd7);
        cmd_valid = '0;
        check(op1[0] === 1'b0, "t1_not_yet", 32'(op1[0]), 0);
        cycles(1);
        check({op4[0], op3[0], op2[0], op1[0]} === 4'b0001, "t1_strobe", 32'({op4[0], op3[0], op2[0], op1[0]}), 1);
        check({in1[0], in2[0]} === {3'd1, 3'd7}, "t1_operands", 32'({in1[0], in2[0]}), 32'h0f);
        check(icnt[0] === 8'd1, "t1_count", 32'(icnt[0]), 1);
        check(ovf[0] === OVF_ON, "t1_ovf", 32'(ovf[0]), 32'(OVF_ON));
        cycles(1);
        check(op1[0] === 1'b0, "t1_single_pulse", 32'(op1[0]), 0);

        // back-to-back pushes fill the FIFO; the 8th waits for a pop
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check(cmd_ready[0] === 1'b0, "t2_full", 32'(cmd_ready[0]), 0);
            push(0, 2'(i % 4), 3'(i), 3'(7 - i));
        end
        cmd_valid = '0;
        cycles(20);

        // hold of 2: three queued commands issue three cycles apart
        do_reset();
        push(1, OP_SHL, 3'd3, 3'd5);
        push(1, OP_SUB, 3'd2, 3'd6);
        push(1, OP_ADD, 3'd4, 3'd4);
        cmd_valid = '0;
        cycles(12);
        check(scnt[1] == 3, "t3_strobes", 32'(scnt[1]), 3);
        check(slog[1][1] - slog[1][0] == 3, "t3_gap1", 32'(slog[1][1] - slog[1][0]), 3);
        check(slog[1][2] - slog[1][1] == 3, "t3_gap2", 32'(slog[1][2] - slog[1][1]), 3);

        // reset during hold with two entries still queued
        do_reset();
        push(1, OP_SHR, 3'd7, 3'd1);
        push(1, OP_ADD, 3'd2, 3'd3);
        push(1, OP_SUB, 3'd5, 3'd1);
        cmd_valid = '0;
        #2 reset = 1'b1;
        #1;
        check({op4[1], op3[1], op2[1], op1[1], busy[1]} === 5'b0, "t4_async_clear", 32'({op4[1], op3[1], op2[1], op1[1], busy[1]}), 0);
        check({cmd_ready[1], in1[1], icnt[1]} === {1'b1, 3'd0, 8'd0}, "t4_async_regs", 32'({cmd_ready[1], in1[1], icnt[1]}), 32'h800);
        cycles(2);
        reset = 1'b0;
        cycles(8);
        check(scnt[1] == 0, "t4_no_strobe", 32'(scnt[1]), 0);
        check(busy[1] === 1'b0, "t4_idle", 32'(busy[1]), 0);

        // hold of 0: sustained pushes issue every cycle
        do_reset();
        for (int i = 0; i < 8; i++) push(2, 2'(3 - i % 4), 3'(i * 3), 3'(i + 2));
        cmd_valid = '0;
        cycles(4);
        check(scnt[2] == 8, "t5_strobes", 32'(scnt[2]), 8);
        check(slog[2][7] - slog[2][0] == 7, "t5_consecutive", 32'(slog[2][7] - slog[2][0]), 7);

        // 256 issues wrap the counter, then a borrowing subtract
        do_reset();
        for (int i = 0; i < 256; i++) push(2, 2'(i % 4), 3'(i / 4), 3'(i / 32));
        cmd_valid = '0;
        cycles(4);
        check(icnt[2] === 8'd0, "t6_wrap", 32'(icnt[2]), 0);
        check(scnt[2] == 256, "t6_strobes", 32'(scnt[2]), 256);
        push(2, OP_SUB, 3'd0, 3'd4);
        cmd_valid = '0;
        cycles(1);
        check(op2[2] === 1'b1, "t6_sub_strobe", 32'(op2[2]), 1);
        check(ovf[2] === OVF_ON, "t6_sub_ovf", 32'(ovf[2]), 32'(OVF_ON));
        check(icnt[2] === 8'd1, "t6_count", 32'(icnt[2]), 1);
        cycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
